imm_gen_stage: RTL

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/riscv_pkg.sv | 15 +
 rtl/tartaruga_pkg.sv | 19 +
 rtl/imm_extract.sv | 47 ++++
 rtl/imm_gen_stage.sv | 83 ++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// RV32/RV64 base opcode constants shared by the decode-side stages.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/tartaruga_pkg.sv
// Core-wide types: immediate formats and the instruction record passed between stages.
package tartaruga_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_fmt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } instr_data_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decoder: picks the format from the opcode and
// builds the extended immediate for an XLEN-wide datapath.
module imm_extract
    import riscv_pkg::*;
    import tartaruga_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o
);

    logic [31:0] imm32;

    always_comb begin
        fmt_o = IMM_NONE;
        case (instr_i[6:0])
            OP_LUI, OP_AUIPC:        fmt_o = IMM_U;
            OP_ALU_I, OP_LW, OP_JALR: fmt_o = IMM_I;
            OP_SW:                   fmt_o = IMM_S;
            OP_BRANCH:               fmt_o = IMM_B;
            OP_JAL:                  fmt_o = IMM_J;
            OP_SYSTEM:               fmt_o = instr_i[14] ? IMM_Z : IMM_NONE;
            default:                 fmt_o = IMM_NONE;
        endcase
    end

    // Every format fits in 32 bits with its sign already in bit 31 (Z is
    // positive), so widening to XLEN is a single signed cast.
    always_comb begin
        imm32 = '0;
        case (fmt_o)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            IMM_Z: imm32 = {27'b0, instr_i[19:15]};
            default: imm32 = '0;
        endcase
        imm_o = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: extracts the immediate and buffers it
// with its instruction in a two-entry output/skid buffer.
module imm_gen_stage
    import tartaruga_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  instr_data_t     instr_i,
    output logic            valid_o,
    input  logic            ready_i,
    output instr_data_t     instr_o,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        imm_fmt_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and ready_o is a pure register
    // (the skid slot is empty) so ready_i never reaches ready_o combinationally.

    logic [XLEN-1:0] ext_imm;
    imm_fmt_t        ext_fmt;

    logic            skid_valid;
    instr_data_t     skid_instr;
    logic [XLEN-1:0] skid_imm;
    imm_fmt_t        skid_fmt;

    logic accept;
    logic out_free;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i (instr_i.word),
        .imm_o   (ext_imm),
        .fmt_o   (ext_fmt)
    );

    assign ready_o  = ~skid_valid;
    assign accept   = valid_i & ready_o;
    assign out_free = ~valid_o | ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            instr_o    <= '0;
            imm_o      <= '0;
            imm_fmt_o  <= IMM_NONE;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_imm   <= '0;
            skid_fmt   <= IMM_NONE;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            // Skid full implies ready_o=0, so it never races a new accept.
            if (skid_valid) begin
                valid_o    <= 1'b1;
                instr_o    <= skid_instr;
                imm_o      <= skid_imm;
                imm_fmt_o  <= skid_fmt;
                skid_valid <= 1'b0;
            end else if (accept) begin
                valid_o   <= 1'b1;
                instr_o   <= instr_i;
                imm_o     <= ext_imm;
                imm_fmt_o <= ext_fmt;
            end else begin
                valid_o <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_instr <= instr_i;
            skid_imm   <= ext_imm;
            skid_fmt   <= ext_fmt;
        end
    end

endmodule
